xgmii_rs: RTL and testbench
===========================

XGMII_RS -- requirements
Module: xgmii_rs

Interface
REQ-001 SHALL have parameter FAULT_WINDOW, default 128, meaning the number of 72-bit words in a fault qualification/clear window.
REQ-002 SHALL have parameter FAULT_THRESH, default 4, meaning the fault sequences needed within a window to declare a fault.
REQ-003 SHALL have port clk  input  1  single clock (156.25 MHz XGMII clock).
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_dc  input  72  PHY receive word; lane i = bits [9i+8:9i], data [9i+7:9i], ctrl bit 9i+8.
REQ-006 SHALL have port tx_in_dc  input  72  MAC transmit word, same lane format.
REQ-007 SHALL have port tx_out_dc  output  72  transmit word to PHY.
REQ-008 SHALL have port link_up  output  1  no local or remote fault.
REQ-009 SHALL have port local_fault  output  1  local fault declared.
REQ-010 SHALL have port remote_fault  output  1  remote fault declared.
REQ-011 SHALL have port frame_count  output  32  received start-of-frame count, saturating.
REQ-012 SHALL have port error_count  output  16  received error-character count, saturating.

Function
REQ-013 SHALL define a column as lanes 0-3 or lanes 4-7 of a word.
REQ-014 SHALL decode a column as a local-fault sequence when it is {ctrl1:0x9C, ctrl0:0x00, ctrl0:0x00, ctrl0:0x01}.
REQ-015 SHALL decode a column as a remote-fault sequence when it is {ctrl1:0x9C, ctrl0:0x00, ctrl0:0x00, ctrl0:0x02}.
REQ-016 SHALL classify a word containing any local-fault column as type LF, else any remote-fault column as RF, else NONE (LF takes precedence).
REQ-017 SHALL implement the states OK, LF, RF, with reset state OK.
REQ-018 SHALL keep seq_type, a fault counter (saturating at FAULT_THRESH), and a window counter (0..FAULT_WINDOW-1).
REQ-019 SHALL, on an LF/RF word whose type equals seq_type, increment the fault counter and clear the window counter.
REQ-020 SHALL, on an LF/RF word whose type differs from seq_type, set seq_type to the new type, set the fault counter to 1, and clear the window counter.
REQ-021 SHALL, on a NONE word, increment the window counter, and on reaching FAULT_WINDOW clear both counters and the window counter.
REQ-022 SHALL enter the state given by seq_type when the fault counter reaches FAULT_THRESH, including a direct LF<->RF change.
REQ-023 SHALL return from LF or RF to OK after FAULT_WINDOW consecutive NONE words.
REQ-024 SHALL register local_fault, remote_fault and link_up = (state==OK), updating one cycle after the deciding word.
REQ-025 SHALL increment frame_count once per lane carrying ctrl1:0xFB in lane 0 or lane 4, adding 2 if both lanes carry it.
REQ-026 SHALL increment error_count by the number of lanes carrying ctrl1:0xFE (0..8).
REQ-027 SHALL saturate both counters at all-ones, with no wrap.
REQ-028 SHALL register tx_out_dc with 1-cycle latency.
REQ-029 SHALL drive tx_out_dc = tx_in_dc in state OK.
REQ-030 SHALL drive tx_out_dc as a remote-fault sequence in both columns in state LF.
REQ-031 SHALL drive tx_out_dc as an idle word (every lane ctrl1:0x07) in state RF.
REQ-032 SHALL apply a state change to tx_out_dc on the same cycle that the status outputs change.

Reset
REQ-033 SHALL, while rst is high at a clk edge, set state=OK, all counters=0, seq_type=NONE, and link_up=1, local_fault=0, remote_fault=0, frame_count=0, error_count=0, tx_out_dc=idle word.
REQ-034 SHALL, on reset asserted mid-qualification, discard partial fault counts, with no fault declared after release until FAULT_THRESH new sequences arrive.

Verification
REQ-035 SHALL verify: 4 LF words, each 10 idle words apart -> local_fault=1 one cycle after the 4th, and tx_out_dc = RF sequence on both columns.
REQ-036 SHALL verify: 3 LF words, then 128 idles, then 1 LF -> local_fault stays 0.
REQ-037 SHALL verify: in state LF, 127 idles then 1 RF word -> LF is held; then 4 RF words -> remote_fault=1, local_fault=0, tx_out_dc = idle.
REQ-038 SHALL verify: in state RF, 128 idles -> link_up=1 and tx_out_dc follows tx_in_dc with 1-cycle delay.
REQ-039 SHALL verify: a word with 0xFB in lanes 0 and 4 and 0xFE in 3 lanes -> frame_count += 2, error_count += 3; with error_count preloaded near 0xFFFF via stimulus -> it saturates at 0xFFFF.
REQ-040 SHALL verify: rst pulsed after 3 RF words, then 1 RF word -> remote_fault stays 0 and all outputs match reset values.

Source files
------------

// File: rtl/xgmii_rs.sv
// XGMII reconciliation sublayer: link fault signalling state machine, transmit
// fault override and receive start/error statistics, all registered.
module xgmii_rs #(
    parameter int FAULT_WINDOW = 128,
    parameter int FAULT_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] rx_dc,
    input  logic [71:0] tx_in_dc,
    output logic [71:0] tx_out_dc,
    output logic        link_up,
    output logic        local_fault,
    output logic        remote_fault,
    output logic [31:0] frame_count,
    output logic [15:0] error_count
);
    localparam int FW = $clog2(FAULT_THRESH + 1);
    localparam int WW = $clog2(FAULT_WINDOW + 1);

    localparam logic [35:0] IDLE_COL = {4{9'h107}};
    localparam logic [35:0] RF_COL   = {9'h002, 9'h000, 9'h000, 9'h19C};
    localparam logic [71:0] IDLE_WORD = {IDLE_COL, IDLE_COL};
    localparam logic [71:0] RF_WORD   = {RF_COL, RF_COL};

    typedef enum logic [1:0] {ST_OK = 2'd0, ST_LF = 2'd1, ST_RF = 2'd2} state_t;
    typedef enum logic [1:0] {SEQ_NONE = 2'd0, SEQ_LF = 2'd1, SEQ_RF = 2'd2} seq_t;

    // Lane 0 of the column carries the sequence control, lane 3 the fault code.
    function automatic logic is_seq_col(input logic [35:0] col, input logic [7:0] code);
        return col == {1'b0, code, 9'h000, 9'h000, 9'h19C};
    endfunction

    state_t        state_r, state_s;
    seq_t          seq_r, seq_s, word_type_s;
    logic [FW-1:0] fcnt_r, fcnt_s;
    logic [WW-1:0] wcnt_r, wcnt_s;
    logic          lf_word_s, rf_word_s;
    logic [1:0]    sof_s;
    logic [3:0]    nerr_s;
    logic [32:0]   frame_sum_s;
    logic [16:0]   err_sum_s;
    logic [71:0]   tx_s;

    assign lf_word_s   = is_seq_col(rx_dc[35:0], 8'h01) | is_seq_col(rx_dc[71:36], 8'h01);
    assign rf_word_s   = is_seq_col(rx_dc[35:0], 8'h02) | is_seq_col(rx_dc[71:36], 8'h02);
    assign word_type_s = lf_word_s ? SEQ_LF : (rf_word_s ? SEQ_RF : SEQ_NONE);

    // State and fault-qualification counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OK;
            seq_r   <= SEQ_NONE;
            fcnt_r  <= '0;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            seq_r   <= seq_s;
            fcnt_r  <= fcnt_s;
            wcnt_r  <= wcnt_s;
        end
    end

    // Next state: fault sequences qualify, a full window of clean words clears
    always_comb begin
        state_s = state_r;
        seq_s   = seq_r;
        fcnt_s  = fcnt_r;
        wcnt_s  = wcnt_r;
        if (word_type_s != SEQ_NONE) begin
            wcnt_s = '0;
            if (word_type_s == seq_r) begin
                if (fcnt_r < FW'(FAULT_THRESH)) begin
                    fcnt_s = fcnt_r + FW'(1);
                end else begin
                    fcnt_s = fcnt_r;
                end
            end else begin
                seq_s  = word_type_s;
                fcnt_s = FW'(1);
            end
            if (fcnt_s >= FW'(FAULT_THRESH)) begin
                state_s = (seq_s == SEQ_LF) ? ST_LF : ST_RF;
            end else begin
                state_s = state_r;
            end
        end else if (wcnt_r == WW'(FAULT_WINDOW - 1)) begin
            wcnt_s  = '0;
            fcnt_s  = '0;
            state_s = ST_OK;
        end else begin
            wcnt_s = wcnt_r + WW'(1);
        end
    end

    // Output decode: transmit override and receive statistics increments
    always_comb begin
        sof_s  = {1'b0, rx_dc[8:0] == 9'h1FB} + {1'b0, rx_dc[44:36] == 9'h1FB};
        nerr_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (rx_dc[9*i +: 9] == 9'h1FE) begin
                nerr_s = nerr_s + 4'd1;
            end else begin
                nerr_s = nerr_s;
            end
        end
        frame_sum_s = {1'b0, frame_count} + {31'd0, sof_s};
        err_sum_s   = {1'b0, error_count} + {13'd0, nerr_s};
        case (state_s)
            ST_OK:   tx_s = tx_in_dc;
            ST_LF:   tx_s = RF_WORD;
            ST_RF:   tx_s = IDLE_WORD;
            default: tx_s = IDLE_WORD;
        endcase
    end

    // Output registers; status and transmit word change on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_out_dc    <= IDLE_WORD;
            link_up      <= 1'b1;
            local_fault  <= 1'b0;
            remote_fault <= 1'b0;
            frame_count  <= 32'd0;
            error_count  <= 16'd0;
        end else begin
            tx_out_dc    <= tx_s;
            link_up      <= (state_s == ST_OK);
            local_fault  <= (state_s == ST_LF);
            remote_fault <= (state_s == ST_RF);
            frame_count  <= frame_sum_s[32] ? 32'hFFFF_FFFF : frame_sum_s[31:0];
            error_count  <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        end
    end
endmodule

// File: tb/tb_xgmii_rs.sv
// Directed bench for xgmii_rs: a vector table for pass-through and statistics,
// then hand-written sequences for fault qualification, clearing and reset.
module tb_xgmii_rs;
    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] rx_dc, tx_in_dc, tx_out_dc;
    logic        link_up, local_fault, remote_fault;
    logic [31:0] frame_count;
    logic [15:0] error_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [35:0] IDLE_COL = {4{9'h107}};
    localparam logic [35:0] LF_COL   = {9'h001, 9'h000, 9'h000, 9'h19C};
    localparam logic [35:0] RF_COL   = {9'h002, 9'h000, 9'h000, 9'h19C};
    localparam logic [71:0] IDLE_W   = {IDLE_COL, IDLE_COL};
    localparam logic [71:0] LF_W     = {IDLE_COL, LF_COL};
    localparam logic [71:0] RF_W     = {RF_COL, IDLE_COL};
    localparam logic [71:0] RFSEQ_W  = {RF_COL, RF_COL};
    localparam logic [71:0] ALLFE_W  = {8{9'h1FE}};

    xgmii_rs #(.FAULT_WINDOW(128), .FAULT_THRESH(4)) dut (
        .clk(clk), .rst(rst), .rx_dc(rx_dc), .tx_in_dc(tx_in_dc),
        .tx_out_dc(tx_out_dc), .link_up(link_up), .local_fault(local_fault),
        .remote_fault(remote_fault), .frame_count(frame_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] rx;
        logic [71:0] tx_in;
        logic [71:0] exp_tx;
        logic        exp_link;
        logic [31:0] exp_frames;
        logic [15:0] exp_errs;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [71:0] put(input logic [71:0] w, input int lane, input logic [8:0] v);
        logic [71:0] r;
        r = w;
        r[9*lane +: 9] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [71:0] rx, input logic [71:0] txin);
        rx_dc    = rx;
        tx_in_dc = txin;
        @(posedge clk);
        #1;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(IDLE_W, 72'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(IDLE_W, 72'd0);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_link"},   {71'd0, link_up},      72'd1);
        chk({tag, "_lf"},     {71'd0, local_fault},  72'd0);
        chk({tag, "_rf"},     {71'd0, remote_fault}, 72'd0);
        chk({tag, "_frames"}, {40'd0, frame_count},  72'd0);
        chk({tag, "_errs"},   {56'd0, error_count},  72'd0);
        chk({tag, "_tx"},     tx_out_dc,             IDLE_W);
    endtask

    initial begin
        rst      = 1'b1;
        rx_dc    = IDLE_W;
        tx_in_dc = 72'd0;

        vecs[0] = '{IDLE_W, 72'h12_3456_789A_BCDE_F012, 72'h12_3456_789A_BCDE_F012, 1'b1, 32'd0, 16'd0};
        vecs[1] = '{put(IDLE_W, 0, 9'h1FB), 72'hAB_CDEF_0123_4567_89AB, 72'hAB_CDEF_0123_4567_89AB, 1'b1, 32'd1, 16'd0};
        vecs[2] = '{put(put(IDLE_W, 1, 9'h1FE), 2, 9'h1FE), 72'hFF_0000_FFFF_0000_FFFF, 72'hFF_0000_FFFF_0000_FFFF, 1'b1, 32'd1, 16'd2};
        vecs[3] = '{put(put(IDLE_W, 4, 9'h1FB), 7, 9'h1FE), 72'h55_AAAA_5555_AAAA_5555, 72'h55_AAAA_5555_AAAA_5555, 1'b1, 32'd2, 16'd3};
        vecs[4] = '{put(IDLE_W, 2, 9'h1FB), 72'h01, 72'h01, 1'b1, 32'd2, 16'd3};
        vecs[5] = '{put(put(put(put(put(IDLE_W, 0, 9'h1FB), 4, 9'h1FB), 1, 9'h1FE), 5, 9'h1FE), 6, 9'h1FE),
                    72'hC3_C3C3_C3C3_C3C3_C3C3, 72'hC3_C3C3_C3C3_C3C3_C3C3, 1'b1, 32'd4, 16'd6};
        vecs[6] = '{put(IDLE_W, 3, 9'h0FE), 72'h80_0000_0000_0000_0001, 72'h80_0000_0000_0000_0001, 1'b1, 32'd4, 16'd6};

        do_reset();
        chk_reset_state("reset");

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rx, vecs[i].tx_in);
            chk($sformatf("vec%0d_tx", i),     tx_out_dc,               vecs[i].exp_tx);
            chk($sformatf("vec%0d_link", i),   {71'd0, link_up},        {71'd0, vecs[i].exp_link});
            chk($sformatf("vec%0d_frames", i), {40'd0, frame_count},    {40'd0, vecs[i].exp_frames});
            chk($sformatf("vec%0d_errs", i),   {56'd0, error_count},    {56'd0, vecs[i].exp_errs});
        end

        // Four LF words spaced by ten idles declare a local fault
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(LF_W, 72'h77);
            idles(10);
        end
        chk("lf3_not_declared", {71'd0, local_fault}, 72'd0);
        step(LF_W, 72'h77);
        chk("lf4_local_fault", {71'd0, local_fault}, 72'd1);
        chk("lf4_link_down",   {71'd0, link_up},     72'd0);
        chk("lf4_tx_rfseq",    tx_out_dc,            RFSEQ_W);

        // In LF: 127 idles keep LF, one RF word keeps LF, four RF words switch to RF
        idles(127);
        chk("lf_127idle_held", {71'd0, local_fault}, 72'd1);
        step(RF_W, 72'h77);
        chk("lf_1rf_held", {71'd0, local_fault}, 72'd1);
        chk("lf_1rf_tx",   tx_out_dc,            RFSEQ_W);
        for (int k = 0; k < 4; k++) step(RF_W, 72'h77);
        chk("rf_remote", {71'd0, remote_fault}, 72'd1);
        chk("rf_local",  {71'd0, local_fault},  72'd0);
        chk("rf_tx_idle", tx_out_dc, IDLE_W);

        // In RF: 127 idles hold, the 128th returns to OK with pass-through
        idles(127);
        chk("rf_127idle_held", {71'd0, remote_fault}, 72'd1);
        step(IDLE_W, 72'h3C_DEAD_BEEF_CAFE_F00D);
        chk("rf_clear_link", {71'd0, link_up},      72'd1);
        chk("rf_clear_rf",   {71'd0, remote_fault}, 72'd0);
        chk("rf_clear_tx",   tx_out_dc,             72'h3C_DEAD_BEEF_CAFE_F00D);
        step(IDLE_W, 72'h11_2233_4455_6677_8899);
        chk("ok_passthru", tx_out_dc, 72'h11_2233_4455_6677_8899);

        // Window boundary: 127 idles keep the count, 128 idles discard it
        do_reset();
        for (int k = 0; k < 3; k++) step({LF_COL, IDLE_COL}, 72'd0);
        idles(127);
        step(LF_W, 72'd0);
        chk("win127_declared", {71'd0, local_fault}, 72'd1);
        do_reset();
        for (int k = 0; k < 3; k++) step(LF_W, 72'd0);
        idles(128);
        step(LF_W, 72'd0);
        chk("win128_cleared", {71'd0, local_fault}, 72'd0);
        for (int k = 0; k < 3; k++) step(LF_W, 72'd0);
        chk("win128_requalify", {71'd0, local_fault}, 72'd1);

        // Error counter preload and saturation
        do_reset();
        for (int k = 0; k < 8191; k++) step(ALLFE_W, 72'd0);
        chk("err_preload", {56'd0, error_count}, 72'd65528);
        step(put(put(put(put(put(IDLE_W, 0, 9'h1FB), 4, 9'h1FB), 1, 9'h1FE), 2, 9'h1FE), 3, 9'h1FE), 72'd0);
        chk("sof2_frames", {40'd0, frame_count}, 72'd2);
        chk("fe3_errs",    {56'd0, error_count}, 72'd65531);
        step(ALLFE_W, 72'd0);
        chk("err_sat", {56'd0, error_count}, 72'hFFFF);
        step(ALLFE_W, 72'd0);
        chk("err_sat_hold", {56'd0, error_count}, 72'hFFFF);

        // Reset mid-qualification discards partial RF counts
        for (int k = 0; k < 3; k++) step(RF_W, 72'd0);
        do_reset();
        chk_reset_state("midreset");
        step(RF_W, 72'd0);
        chk("midreset_1rf_rf",   {71'd0, remote_fault}, 72'd0);
        chk("midreset_1rf_link", {71'd0, link_up},      72'd1);
        for (int k = 0; k < 3; k++) step(RF_W, 72'd0);
        chk("midreset_4rf_rf", {71'd0, remote_fault}, 72'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
